// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and flag decode for the single-clock FIFO.
// Pointer and count values are carried at MAX_PTR_W bits when passed into the shared decode.
package sync_fifo_pkg;

   localparam int MAX_ADDR_WIDTH = 10;
   localparam int MAX_PTR_W      = MAX_ADDR_WIDTH + 1;

   typedef struct packed {
      logic empty;
      logic almost_empty;
      logic almost_full;
      logic full;
   } fifo_flags_t;

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   // One extra MSB separates the full and empty cases when the low bits match.
   function automatic int ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

   function automatic fifo_flags_t decode_flags(input logic [MAX_PTR_W-1:0] count,
                                                input int depth,
                                                input int ae_buf,
                                                input int af_buf);
      fifo_flags_t f;
      int c;
      c              = int'(count);
      f.empty        = (c == 0);
      f.full         = (c == depth);
      f.almost_empty = (c <= ae_buf);
      f.almost_full  = (c >= depth - af_buf);
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bundle of the single-clock FIFO; _i/_o named from the FIFO side.
// SYNC_FIFO_CTRL_ERR_FLAGS_EN adds the sticky overflow_o/underflow_o signals.
interface sync_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
);
   import sync_fifo_pkg::*;

   logic                             wr_en_i;
   logic [DATA_WIDTH-1:0]            wdata_i;
   logic                             full_o;
   logic                             almost_full_o;
   logic                             rd_en_i;
   logic [DATA_WIDTH-1:0]            rdata_o;
   logic                             rvalid_o;
   logic                             empty_o;
   logic                             almost_empty_o;
   logic [ptr_width(ADDR_WIDTH)-1:0] count_o;
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
   logic                             overflow_o;
   logic                             underflow_o;
`endif

   modport master (
      output wr_en_i, wdata_i, rd_en_i,
      input  full_o, almost_full_o, rdata_o, rvalid_o, empty_o, almost_empty_o, count_o
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
      , input overflow_o, underflow_o
`endif
   );

   modport slave (
      input  wr_en_i, wdata_i, rd_en_i,
      output full_o, almost_full_o, rdata_o, rvalid_o, empty_o, almost_empty_o, count_o
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
      , output overflow_o, underflow_o
`endif
   );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array with synchronous write and a read port that is
// combinational (FWFT != 0) or registered with a reset-cleared output (FWFT == 0).
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int FWFT       = 0
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   // Storage is deliberately not reset; the pointers alone define valid contents.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   if (FWFT != 0) begin : g_comb_rd
      logic unused_rd_ctrl;
      assign unused_rd_ctrl = reset_i ^ rd_en_i;
      assign rdata_o        = mem_q[raddr_i];
   end else begin : g_reg_rd
      logic [DATA_WIDTH-1:0] rdata_q;
      logic [DATA_WIDTH-1:0] rdata_d;

      assign rdata_d = rd_en_i ? mem_q[raddr_i] : rdata_q;

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            rdata_q <= '0;
         end else begin
            rdata_q <= rdata_d;
         end
      end

      assign rdata_o = rdata_q;
   end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: binary wrap pointers, fill count, almost flags, FWFT or registered read.
// Define SYNC_FIFO_CTRL_ERR_FLAGS_EN for sticky overflow_o/underflow_o.
module sync_fifo_ctrl
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH          = 16,
   parameter int ADDR_WIDTH          = 3,
   parameter int ALMOST_EMPTY_BUFFER = 2,
   parameter int ALMOST_FULL_BUFFER  = 2,
   parameter int FWFT                = 0
) (
   input  logic            clk_i,
   input  logic            reset_i,
   sync_fifo_ctrl_if.slave fifo
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);
   localparam int PW    = ptr_width(ADDR_WIDTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count;
   fifo_flags_t   flags;
   logic          wr_accept;
   logic          rd_accept;

   assign count = wr_ptr_q - rd_ptr_q;
   assign flags = decode_flags(MAX_PTR_W'(count), DEPTH, ALMOST_EMPTY_BUFFER, ALMOST_FULL_BUFFER);

   // A pop in the same cycle frees the slot, so a write at full still goes in.
   assign rd_accept = fifo.rd_en_i & ~flags.empty;
   assign wr_accept = fifo.wr_en_i & (~flags.full | rd_accept);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .FWFT       (FWFT)
   ) u_mem (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .wr_en_i (wr_accept & ~reset_i),
      .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wdata_i (fifo.wdata_i),
      .rd_en_i (rd_accept & ~reset_i),
      .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata_o (fifo.rdata_o)
   );

   if (FWFT != 0) begin : g_fwft_valid
      assign fifo.rvalid_o = ~flags.empty;
   end else begin : g_reg_valid
      logic rvalid_q, rvalid_d;

      assign rvalid_d = rd_accept;

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            rvalid_q <= 1'b0;
         end else begin
            rvalid_q <= rvalid_d;
         end
      end

      assign fifo.rvalid_o = rvalid_q;
   end

   assign fifo.count_o        = count;
   assign fifo.empty_o        = flags.empty;
   assign fifo.almost_empty_o = flags.almost_empty;
   assign fifo.full_o         = flags.full;
   assign fifo.almost_full_o  = flags.almost_full;

`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   assign overflow_d  = overflow_q | (fifo.wr_en_i & flags.full & ~rd_accept);
   assign underflow_d = underflow_q | (fifo.rd_en_i & flags.empty);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign fifo.overflow_o  = overflow_q;
   assign fifo.underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: a registered-read instance (if0) and an FWFT instance (if1).
// Error-flag checks are compiled in when SYNC_FIFO_CTRL_ERR_FLAGS_EN is defined.
module tb_sync_fifo_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   sync_fifo_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) if0 ();
   sync_fifo_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) if1 ();

   sync_fifo_ctrl #(
      .DATA_WIDTH(16), .ADDR_WIDTH(3), .ALMOST_EMPTY_BUFFER(2), .ALMOST_FULL_BUFFER(2), .FWFT(0)
   ) u_dut0 (
      .clk_i   (clk),
      .reset_i (rst),
      .fifo    (if0)
   );

   sync_fifo_ctrl #(
      .DATA_WIDTH(16), .ADDR_WIDTH(3), .ALMOST_EMPTY_BUFFER(2), .ALMOST_FULL_BUFFER(2), .FWFT(1)
   ) u_dut1 (
      .clk_i   (clk),
      .reset_i (rst),
      .fifo    (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      cycle();
      n_checks++; if (if0.count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", if0.count_o); end
      n_checks++; if (if0.empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", if0.empty_o); end
      n_checks++; if (if0.almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty: got %b expected 1", if0.almost_empty_o); end
      n_checks++; if (if0.full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", if0.full_o); end
      n_checks++; if (if0.almost_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b expected 0", if0.almost_full_o); end
      n_checks++; if (if0.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", if0.rvalid_o); end
      n_checks++; if (if0.rdata_o !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", if0.rdata_o); end
      n_checks++; if (if1.empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_fwft_empty: got %b expected 1", if1.empty_o); end
      n_checks++; if (if1.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_fwft_rvalid: got %b expected 0", if1.rvalid_o); end
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
      n_checks++; if (if0.overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", if0.overflow_o); end
      n_checks++; if (if0.underflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b expected 0", if0.underflow_o); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_fill();
      logic [3:0] exp_cnt;
      logic       exp_af, exp_full, exp_ae;
      for (int i = 1; i <= 8; i++) begin
         if0.wr_en_i = 1'b1;
         if0.wdata_i = 16'(i);
         cycle();
         exp_cnt  = 4'(i);
         exp_af   = (i >= 6);
         exp_full = (i == 8);
         exp_ae   = (i <= 2);
         n_checks++; if (if0.count_o !== exp_cnt) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, if0.count_o, exp_cnt); end
         n_checks++; if (if0.empty_o !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, if0.empty_o); end
         n_checks++; if (if0.almost_full_o !== exp_af) begin n_fail++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, if0.almost_full_o, exp_af); end
         n_checks++; if (if0.full_o !== exp_full) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, if0.full_o, exp_full); end
         n_checks++; if (if0.almost_empty_o !== exp_ae) begin n_fail++; $display("FAIL fill_almost_empty[%0d]: got %b expected %b", i, if0.almost_empty_o, exp_ae); end
      end
      if0.wr_en_i = 1'b0;
   endtask

   task automatic test_drain_registered();
      logic [3:0]  exp_cnt;
      logic [15:0] exp_data;
      logic        exp_empty, exp_ae;
      for (int k = 1; k <= 8; k++) begin
         if0.rd_en_i = 1'b1;
         cycle();
         exp_cnt   = 4'(8 - k);
         exp_data  = 16'(k);
         exp_empty = (k == 8);
         exp_ae    = ((8 - k) <= 2);
         n_checks++; if (if0.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL drain_rvalid[%0d]: got %b expected 1", k, if0.rvalid_o); end
         n_checks++; if (if0.rdata_o !== exp_data) begin n_fail++; $display("FAIL drain_rdata[%0d]: got %h expected %h", k, if0.rdata_o, exp_data); end
         n_checks++; if (if0.count_o !== exp_cnt) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", k, if0.count_o, exp_cnt); end
         n_checks++; if (if0.empty_o !== exp_empty) begin n_fail++; $display("FAIL drain_empty[%0d]: got %b expected %b", k, if0.empty_o, exp_empty); end
         n_checks++; if (if0.almost_empty_o !== exp_ae) begin n_fail++; $display("FAIL drain_almost_empty[%0d]: got %b expected %b", k, if0.almost_empty_o, exp_ae); end
      end
      // read request on an empty FIFO is ignored and rdata_o holds the last word
      cycle();
      n_checks++; if (if0.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL empty_read_rvalid: got %b expected 0", if0.rvalid_o); end
      n_checks++; if (if0.rdata_o !== 16'h0008) begin n_fail++; $display("FAIL empty_read_hold: got %h expected 0008", if0.rdata_o); end
      n_checks++; if (if0.count_o !== 4'd0) begin n_fail++; $display("FAIL empty_read_count: got %0d expected 0", if0.count_o); end
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
      n_checks++; if (if0.underflow_o !== 1'b1) begin n_fail++; $display("FAIL underflow_set: got %b expected 1", if0.underflow_o); end
`endif
      if0.rd_en_i = 1'b0;
   endtask

   task automatic test_empty_rw();
      if0.wr_en_i = 1'b1;
      if0.rd_en_i = 1'b1;
      if0.wdata_i = 16'h00AA;
      cycle();
      n_checks++; if (if0.count_o !== 4'd1) begin n_fail++; $display("FAIL empty_rw_count: got %0d expected 1", if0.count_o); end
      n_checks++; if (if0.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL empty_rw_rvalid: got %b expected 0", if0.rvalid_o); end
      if0.wr_en_i = 1'b0;
      cycle();
      n_checks++; if (if0.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL empty_rw_pop_rvalid: got %b expected 1", if0.rvalid_o); end
      n_checks++; if (if0.rdata_o !== 16'h00AA) begin n_fail++; $display("FAIL empty_rw_pop_rdata: got %h expected 00aa", if0.rdata_o); end
      n_checks++; if (if0.count_o !== 4'd0) begin n_fail++; $display("FAIL empty_rw_pop_count: got %0d expected 0", if0.count_o); end
      if0.rd_en_i = 1'b0;
   endtask

   task automatic test_fwft();
      if1.wr_en_i = 1'b1;
      if1.wdata_i = 16'hBEEF;
      cycle();
      if1.wr_en_i = 1'b0;
      n_checks++; if (if1.empty_o !== 1'b0) begin n_fail++; $display("FAIL fwft_empty: got %b expected 0", if1.empty_o); end
      n_checks++; if (if1.rdata_o !== 16'hBEEF) begin n_fail++; $display("FAIL fwft_rdata: got %h expected beef", if1.rdata_o); end
      n_checks++; if (if1.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL fwft_rvalid: got %b expected 1", if1.rvalid_o); end
      cycle();
      n_checks++; if (if1.rdata_o !== 16'hBEEF) begin n_fail++; $display("FAIL fwft_rdata_hold: got %h expected beef", if1.rdata_o); end
      if1.rd_en_i = 1'b1;
      cycle();
      if1.rd_en_i = 1'b0;
      n_checks++; if (if1.empty_o !== 1'b1) begin n_fail++; $display("FAIL fwft_pop_empty: got %b expected 1", if1.empty_o); end
      n_checks++; if (if1.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL fwft_pop_rvalid: got %b expected 0", if1.rvalid_o); end
      if1.wr_en_i = 1'b1;
      if1.wdata_i = 16'h1111;
      cycle();
      if1.wdata_i = 16'h2222;
      cycle();
      if1.wr_en_i = 1'b0;
      n_checks++; if (if1.rdata_o !== 16'h1111) begin n_fail++; $display("FAIL fwft_head1: got %h expected 1111", if1.rdata_o); end
      if1.rd_en_i = 1'b1;
      cycle();
      if1.rd_en_i = 1'b0;
      n_checks++; if (if1.rdata_o !== 16'h2222) begin n_fail++; $display("FAIL fwft_head2: got %h expected 2222", if1.rdata_o); end
      n_checks++; if (if1.count_o !== 4'd1) begin n_fail++; $display("FAIL fwft_head2_count: got %0d expected 1", if1.count_o); end
      if1.rd_en_i = 1'b1;
      cycle();
      if1.rd_en_i = 1'b0;
      n_checks++; if (if1.empty_o !== 1'b1) begin n_fail++; $display("FAIL fwft_final_empty: got %b expected 1", if1.empty_o); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_data;
      for (int i = 0; i < 8; i++) begin
         if0.wr_en_i = 1'b1;
         if0.wdata_i = 16'h0100 + 16'(i);
         cycle();
      end
      n_checks++; if (if0.full_o !== 1'b1) begin n_fail++; $display("FAIL b2b_prefill_full: got %b expected 1", if0.full_o); end
      if0.rd_en_i = 1'b1;
      for (int j = 0; j < 20; j++) begin
         if0.wdata_i = 16'h0108 + 16'(j);
         cycle();
         exp_data = 16'h0100 + 16'(j);
         n_checks++; if (if0.count_o !== 4'd8) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 8", j, if0.count_o); end
         n_checks++; if (if0.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid[%0d]: got %b expected 1", j, if0.rvalid_o); end
         n_checks++; if (if0.rdata_o !== exp_data) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", j, if0.rdata_o, exp_data); end
      end
      if0.wr_en_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         exp_data = 16'h0114 + 16'(k);
         n_checks++; if (if0.rdata_o !== exp_data) begin n_fail++; $display("FAIL b2b_drain_rdata[%0d]: got %h expected %h", k, if0.rdata_o, exp_data); end
      end
      if0.rd_en_i = 1'b0;
      n_checks++; if (if0.empty_o !== 1'b1) begin n_fail++; $display("FAIL b2b_final_empty: got %b expected 1", if0.empty_o); end
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
      n_checks++; if (if0.overflow_o !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overflow: got %b expected 0", if0.overflow_o); end
`endif
   endtask

   task automatic test_overflow_drop();
      logic [15:0] exp_data;
      for (int i = 0; i < 8; i++) begin
         if0.wr_en_i = 1'b1;
         if0.wdata_i = 16'h0200 + 16'(i);
         cycle();
      end
      if0.wdata_i = 16'hDEAD;
      cycle();
      if0.wr_en_i = 1'b0;
      n_checks++; if (if0.count_o !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", if0.count_o); end
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
      n_checks++; if (if0.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", if0.overflow_o); end
`endif
      if0.rd_en_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         exp_data = 16'h0200 + 16'(k);
         n_checks++; if (if0.rdata_o !== exp_data) begin n_fail++; $display("FAIL ovf_drain_rdata[%0d]: got %h expected %h", k, if0.rdata_o, exp_data); end
      end
      if0.rd_en_i = 1'b0;
      cycle();
      n_checks++; if (if0.empty_o !== 1'b1) begin n_fail++; $display("FAIL ovf_dropped_empty: got %b expected 1", if0.empty_o); end
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
      n_checks++; if (if0.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", if0.overflow_o); end
      n_checks++; if (if0.underflow_o !== 1'b1) begin n_fail++; $display("FAIL udf_sticky: got %b expected 1", if0.underflow_o); end
`endif
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         if0.wr_en_i = 1'b1;
         if0.wdata_i = 16'h0300 + 16'(i);
         cycle();
      end
      n_checks++; if (if0.count_o !== 4'd5) begin n_fail++; $display("FAIL rstmid_pre_count: got %0d expected 5", if0.count_o); end
      rst         = 1'b1;
      if0.wdata_i = 16'h0BAD;
      if0.rd_en_i = 1'b1;
      cycle();
      rst         = 1'b0;
      if0.wr_en_i = 1'b0;
      if0.rd_en_i = 1'b0;
      n_checks++; if (if0.count_o !== 4'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", if0.count_o); end
      n_checks++; if (if0.empty_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b expected 1", if0.empty_o); end
      n_checks++; if (if0.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid: got %b expected 0", if0.rvalid_o); end
      n_checks++; if (if0.rdata_o !== 16'h0000) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected 0000", if0.rdata_o); end
`ifdef SYNC_FIFO_CTRL_ERR_FLAGS_EN
      n_checks++; if (if0.overflow_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow: got %b expected 0", if0.overflow_o); end
      n_checks++; if (if0.underflow_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_underflow: got %b expected 0", if0.underflow_o); end
`endif
      cycle();
      n_checks++; if (if0.count_o !== 4'd0) begin n_fail++; $display("FAIL rstmid_no_write: got %0d expected 0", if0.count_o); end
      if0.wr_en_i = 1'b1;
      if0.wdata_i = 16'h0400;
      cycle();
      if0.wr_en_i = 1'b0;
      if0.rd_en_i = 1'b1;
      cycle();
      if0.rd_en_i = 1'b0;
      n_checks++; if (if0.rdata_o !== 16'h0400) begin n_fail++; $display("FAIL rstmid_after_rdata: got %h expected 0400", if0.rdata_o); end
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      if0.wr_en_i = 1'b0;
      if0.rd_en_i = 1'b0;
      if0.wdata_i = 16'h0000;
      if1.wr_en_i = 1'b0;
      if1.rd_en_i = 1'b0;
      if1.wdata_i = 16'h0000;
      test_reset();
      test_fill();
      test_drain_registered();
      test_empty_rw();
      test_fwft();
      test_back_to_back();
      test_overflow_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
